// File: rtl/regfile_cmd_controller.sv
// Byte-stream read/write command front end for a P_RegWidth x P_BitWidth register file.
// Optional trailing XOR checksum on write frames when REGCMD_CHECKSUM_EN is defined.
module regfile_cmd_controller #(
    parameter int unsigned P_RegWidth = 8,
    parameter int unsigned P_BitWidth = 16
) (
    input  logic                          In_Clock_50MHz,
    input  logic                          In_Reset,
    input  logic [7:0]                    In_RxData,
    input  logic                          In_RxValid,
    output logic                          Out_RxReady,
    output logic [7:0]                    Out_TxData,
    output logic                          Out_TxValid,
    input  logic                          In_TxReady,
    output logic [$clog2(P_RegWidth)-1:0] Out_Address,
    output logic [P_BitWidth-1:0]         Out_WriteData,
    output logic                          Out_Write,
    output logic                          Out_Read,
    input  logic [P_BitWidth-1:0]         In_ReadData,
    output logic                          Out_Busy,
    output logic                          Out_Error
);

    localparam int unsigned LP_AddrW    = $clog2(P_RegWidth);
    localparam int unsigned LP_NumBytes = P_BitWidth / 8;

    typedef enum logic [2:0] {
        StCmd,
        StWdata,
        StChk,
        StWrite,
        StRead,
        StRwait,
        StSend
    } state_e;

    state_e                r_state;
    state_e                w_state_next;
    logic [LP_AddrW-1:0]   r_addr;
    logic [P_BitWidth-1:0] r_wdata;
    logic [P_BitWidth-1:0] r_tx;
    logic [3:0]            r_cnt;
    logic                  r_bad;
    logic                  r_error;
    logic                  w_rx_hs;
    logic                  w_tx_hs;
    logic                  w_last_byte;
    logic                  w_cmd_oor;
    logic [P_BitWidth-1:0] w_rx_ext;
`ifdef REGCMD_CHECKSUM_EN
    logic [7:0]            r_csum;
`endif

    assign w_rx_hs     = In_RxValid && Out_RxReady;
    assign w_tx_hs     = Out_TxValid && In_TxReady;
    assign w_last_byte = (r_cnt == 4'(LP_NumBytes - 1));
    assign w_cmd_oor   = (32'(In_RxData[6:0]) >= P_RegWidth);

    always_comb begin
        w_rx_ext       = '0;
        w_rx_ext[7:0]  = In_RxData;
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StCmd: begin
                if (w_rx_hs) begin
                    w_state_next = In_RxData[7] ? StWdata : StRead;
                end
            end
            StWdata: begin
                if (w_rx_hs && w_last_byte) begin
`ifdef REGCMD_CHECKSUM_EN
                    w_state_next = StChk;
`else
                    w_state_next = StWrite;
`endif
                end
            end
            StChk: begin
                if (w_rx_hs) begin
                    w_state_next = StWrite;
                end
            end
            StWrite: w_state_next = StCmd;
            StRead:  w_state_next = StRwait;
            StRwait: w_state_next = StSend;
            StSend: begin
                if (w_tx_hs && w_last_byte) begin
                    w_state_next = StCmd;
                end
            end
            default: w_state_next = StCmd;
        endcase
    end

    always_ff @(posedge In_Clock_50MHz) begin
        if (In_Reset) begin
            r_state <= StCmd;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge In_Clock_50MHz) begin
        if (In_Reset) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_tx    <= '0;
            r_cnt   <= '0;
            r_bad   <= 1'b0;
            r_error <= 1'b0;
`ifdef REGCMD_CHECKSUM_EN
            r_csum  <= '0;
`endif
        end else begin
            case (r_state)
                StCmd: begin
                    if (w_rx_hs) begin
                        r_addr <= In_RxData[LP_AddrW-1:0];
                        r_bad  <= w_cmd_oor;
                        r_cnt  <= '0;
                        if (w_cmd_oor) begin
                            r_error <= 1'b1;
                        end
`ifdef REGCMD_CHECKSUM_EN
                        r_csum <= In_RxData;
`endif
                    end
                end
                StWdata: begin
                    if (w_rx_hs) begin
                        r_wdata <= (r_wdata << 8) | w_rx_ext;
                        r_cnt   <= r_cnt + 4'd1;
`ifdef REGCMD_CHECKSUM_EN
                        r_csum  <= r_csum ^ In_RxData;
`endif
                    end
                end
`ifdef REGCMD_CHECKSUM_EN
                StChk: begin
                    if (w_rx_hs && (In_RxData != r_csum)) begin
                        r_bad   <= 1'b1;
                        r_error <= 1'b1;
                    end
                end
`endif
                StRwait: begin
                    // Out-of-range reads return an all-zero word with normal timing
                    r_tx  <= r_bad ? '0 : In_ReadData;
                    r_cnt <= '0;
                end
                StSend: begin
                    if (w_tx_hs) begin
                        r_tx  <= r_tx << 8;
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Strobes and handshake qualifiers are forced low while reset is asserted
    always_comb begin
        Out_RxReady = 1'b0;
        Out_TxValid = 1'b0;
        Out_Write   = 1'b0;
        Out_Read    = 1'b0;
        Out_Busy    = 1'b0;
        if (!In_Reset) begin
            Out_RxReady = (r_state == StCmd) || (r_state == StWdata) || (r_state == StChk);
            Out_TxValid = (r_state == StSend);
            Out_Write   = (r_state == StWrite) && !r_bad;
            Out_Read    = (r_state == StRead) && !r_bad;
            Out_Busy    = (r_state != StCmd);
        end
    end

    assign Out_TxData    = r_tx[P_BitWidth-1 -: 8];
    assign Out_Address   = r_addr;
    assign Out_WriteData = r_wdata;
    assign Out_Error     = r_error;

endmodule
